// File: rtl/noc_pkg.sv
// Shared types for the link transmitter: flit type field encodings and
// the packet-tracking FSM states.
package noc_pkg;

    typedef enum logic [1:0] {
        BODY   = 2'b00,
        HEAD   = 2'b01,
        TAIL   = 2'b10,
        SINGLE = 2'b11
    } flit_type_t;

    typedef enum logic {
        IDLE   = 1'b0,
        PACKET = 1'b1
    } tx_state_t;

endpackage

// File: rtl/credit_counter.sv
// Downstream buffer credit tracker. Starts full, decrements on each
// forwarded flit, increments on each returned credit, and flags a sticky
// overflow if a credit comes back while already full.
module credit_counter #(
    parameter int CREDIT_BITS = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 dec,
    input  logic                 inc,
    output logic [CREDIT_BITS:0] count,
    output logic                 nonzero,
    output logic                 overflow
);

    localparam int                 DEPTH_INT = 2 ** CREDIT_BITS;
    localparam logic [CREDIT_BITS:0] DEPTH   = DEPTH_INT[CREDIT_BITS:0];
    localparam logic [CREDIT_BITS:0] ONE     = {{CREDIT_BITS{1'b0}}, 1'b1};

    logic [CREDIT_BITS:0] count_q, count_d;
    logic                 overflow_q, overflow_d;

    // Next credit count: simultaneous dec and inc cancel out; an extra
    // credit at full is dropped and recorded as an overflow.
    always_comb begin
        count_d    = count_q;
        overflow_d = overflow_q;
        if (dec && !inc) begin
            if (count_q != '0) begin
                count_d = count_q - ONE;
            end
        end else if (inc && !dec) begin
            if (count_q == DEPTH) begin
                overflow_d = 1'b1;
            end else begin
                count_d = count_q + ONE;
            end
        end
    end

    // Credit state registers; reset refills the budget and ignores any
    // credit returned in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q    <= DEPTH;
            overflow_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign count    = count_q;
    assign nonzero  = (count_q != '0);
    assign overflow = overflow_q;

endmodule

// File: rtl/link_tx.sv
// Credit-based link transmitter: pops flits from an upstream FIFO whenever
// downstream space exists, forwards them one cycle later, and tracks packet
// framing to count packets and flag sequence violations.
module link_tx
    import noc_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int CREDIT_BITS = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_pop,
    output logic                  link_valid,
    output logic [DATA_WIDTH-1:0] link_data,
    input  logic                  credit_return,
    output logic [CREDIT_BITS:0]  credits,
    output logic                  pkt_active,
    output logic [15:0]           pkt_count,
    output logic                  proto_err,
    output logic                  credit_err
);

    tx_state_t             state_q;
    logic                  linkValid_q;
    logic [DATA_WIDTH-1:0] linkData_q;
    logic [15:0]           pktCount_q;
    logic                  protoErr_q;
    logic                  creditNonzero;
    flit_type_t            flitType;

    assign flitType = flit_type_t'(fifo_dout[DATA_WIDTH-1:DATA_WIDTH-2]);
    assign fifo_pop = ~reset & ~fifo_empty & creditNonzero;

    credit_counter #(
        .CREDIT_BITS(CREDIT_BITS)
    ) u_credit_counter (
        .clk      (clk),
        .reset    (reset),
        .dec      (fifo_pop),
        .inc      (credit_return),
        .count    (credits),
        .nonzero  (creditNonzero),
        .overflow (credit_err)
    );

    // Forwarding register plus packet FSM; the FSM only moves on pop
    // cycles, and violating flits are still forwarded untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            linkValid_q <= 1'b0;
            linkData_q  <= '0;
            pktCount_q  <= '0;
            protoErr_q  <= 1'b0;
        end else begin
            linkValid_q <= fifo_pop;
            if (fifo_pop) begin
                linkData_q <= fifo_dout;
                case (state_q)
                    IDLE: begin
                        case (flitType)
                            HEAD:    state_q    <= PACKET;
                            SINGLE:  pktCount_q <= pktCount_q + 16'd1;
                            default: protoErr_q <= 1'b1;
                        endcase
                    end
                    PACKET: begin
                        case (flitType)
                            BODY: state_q <= PACKET;
                            TAIL: begin
                                state_q    <= IDLE;
                                pktCount_q <= pktCount_q + 16'd1;
                            end
                            HEAD: protoErr_q <= 1'b1;
                            SINGLE: begin
                                protoErr_q <= 1'b1;
                                pktCount_q <= pktCount_q + 16'd1;
                            end
                        endcase
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign link_valid = linkValid_q;
    assign link_data  = linkData_q;
    assign pkt_count  = pktCount_q;
    assign proto_err  = protoErr_q;
    assign pkt_active = (state_q == PACKET);

endmodule

// File: tb/tb_link_tx.sv
// Self-checking bench for link_tx: directed scenarios followed by random
// traffic, all compared against a transaction-level reference model.
module tb_link_tx;

    localparam int DW    = 32;
    localparam int CB    = 3;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          fifoEmpty;
    logic [DW-1:0] fifoDout;
    logic          fifoPop;
    logic          linkValid;
    logic [DW-1:0] linkData;
    logic          creditReturn;
    logic [CB:0]   credits;
    logic          pktActive;
    logic [15:0]   pktCount;
    logic          protoErr;
    logic          creditErr;

    int assertCount = 0;
    int failCount   = 0;
    int popSeen     = 0;
    int activeSeen  = 0;

    // upstream FIFO contents and reference model state
    logic [DW-1:0] fifoQ[$];
    int            mCredits;
    bit            mInPacket;
    bit            mValid;
    logic [DW-1:0] mData;
    int            mPktCount;
    bit            mProtoErr;
    bit            mCreditErr;

    always #5 clk = ~clk;

    link_tx #(
        .DATA_WIDTH (DW),
        .CREDIT_BITS(CB)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .fifo_empty   (fifoEmpty),
        .fifo_dout    (fifoDout),
        .fifo_pop     (fifoPop),
        .link_valid   (linkValid),
        .link_data    (linkData),
        .credit_return(creditReturn),
        .credits      (credits),
        .pkt_active   (pktActive),
        .pkt_count    (pktCount),
        .proto_err    (protoErr),
        .credit_err   (creditErr)
    );

    // Every comparison funnels through here so the tallies stay honest.
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [DW-1:0] mkFlit(input logic [1:0] ftype, input logic [29:0] payload);
        return {ftype, payload};
    endfunction

    // Applies one clock cycle of stimulus, then advances the model by the
    // packet-framing rules and compares every output.
    task automatic applyStimulus(input bit cr, input bit rst);
        bit            empty;
        bit            expPop;
        logic [DW-1:0] head;
        logic [1:0]    ft;
        empty        = (fifoQ.size() == 0);
        head         = empty ? '0 : fifoQ[0];
        fifoEmpty    = empty;
        fifoDout     = head;
        creditReturn = cr;
        reset        = rst;
        expPop       = !rst && !empty && (mCredits != 0);
        #1;
        checkOutput("fifo_pop", {63'd0, fifoPop}, {63'd0, expPop});
        if (fifoPop === 1'b1) popSeen++;
        @(posedge clk);
        if (rst) begin
            mCredits   = DEPTH;
            mInPacket  = 0;
            mValid     = 0;
            mData      = '0;
            mPktCount  = 0;
            mProtoErr  = 0;
            mCreditErr = 0;
        end else begin
            mValid = expPop;
            if (expPop) begin
                mData = head;
                ft    = head[DW-1 -: 2];
                if (!mInPacket) begin
                    if (ft == 2'b01) mInPacket = 1;
                    else if (ft == 2'b11) mPktCount = (mPktCount + 1) % 65536;
                    else mProtoErr = 1;
                end else begin
                    if (ft == 2'b10) begin
                        mInPacket = 0;
                        mPktCount = (mPktCount + 1) % 65536;
                    end else if (ft == 2'b01) begin
                        mProtoErr = 1;
                    end else if (ft == 2'b11) begin
                        mProtoErr = 1;
                        mPktCount = (mPktCount + 1) % 65536;
                    end
                end
                void'(fifoQ.pop_front());
            end
            if (expPop && !cr) mCredits = mCredits - 1;
            else if (cr && !expPop) begin
                if (mCredits == DEPTH) mCreditErr = 1;
                else mCredits = mCredits + 1;
            end
        end
        #1;
        checkOutput("link_valid", {63'd0, linkValid}, {63'd0, mValid});
        checkOutput("link_data", {32'd0, linkData}, {32'd0, mData});
        checkOutput("credits", {60'd0, credits}, 64'(mCredits));
        checkOutput("pkt_active", {63'd0, pktActive}, {63'd0, mInPacket});
        checkOutput("pkt_count", {48'd0, pktCount}, 64'(mPktCount));
        checkOutput("proto_err", {63'd0, protoErr}, {63'd0, mProtoErr});
        checkOutput("credit_err", {63'd0, creditErr}, {63'd0, mCreditErr});
        if (pktActive === 1'b1) activeSeen++;
    endtask

    task automatic doReset();
        fifoQ.delete();
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1);
    endtask

    // Directed scenarios first, then a long random run, then the counter wrap.
    initial begin
        reset        = 1'b1;
        fifoEmpty    = 1'b1;
        fifoDout     = '0;
        creditReturn = 1'b0;
        mCredits     = DEPTH;
        #2;

        // reset values, with a credit return in the reset cycle ignored
        doReset();
        checkOutput("reset_credits", {60'd0, credits}, 64'd8);
        checkOutput("reset_pkt_count", {48'd0, pktCount}, 64'd0);

        // HEAD, BODY, TAIL packet
        fifoQ.push_back(mkFlit(2'b01, 30'h111));
        fifoQ.push_back(mkFlit(2'b00, 30'h222));
        fifoQ.push_back(mkFlit(2'b10, 30'h333));
        popSeen    = 0;
        activeSeen = 0;
        repeat (4) applyStimulus(1'b0, 1'b0);
        checkOutput("pkt3_pops", 64'(popSeen), 64'd3);
        checkOutput("pkt3_credits", {60'd0, credits}, 64'd5);
        checkOutput("pkt3_count", {48'd0, pktCount}, 64'd1);
        checkOutput("pkt3_active_cycles", 64'(activeSeen), 64'd2);

        // credit exhaustion with ten singles, then one credit back
        doReset();
        for (int i = 0; i < 10; i++) fifoQ.push_back(mkFlit(2'b11, 30'(i)));
        popSeen = 0;
        repeat (12) applyStimulus(1'b0, 1'b0);
        checkOutput("exhaust_pops", 64'(popSeen), 64'd8);
        checkOutput("exhaust_credits", {60'd0, credits}, 64'd0);
        popSeen = 0;
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("one_credit_pops", 64'(popSeen), 64'd1);

        // pop and credit return together at credits=3
        doReset();
        for (int i = 0; i < 6; i++) fifoQ.push_back(mkFlit(2'b11, 30'h40 + 30'(i)));
        repeat (5) applyStimulus(1'b0, 1'b0);
        checkOutput("pre_both_credits", {60'd0, credits}, 64'd3);
        applyStimulus(1'b1, 1'b0);
        checkOutput("both_credits", {60'd0, credits}, 64'd3);

        // credit overflow is sticky until reset
        doReset();
        applyStimulus(1'b1, 1'b0);
        checkOutput("ovf_credits", {60'd0, credits}, 64'd8);
        repeat (3) applyStimulus(1'b0, 1'b0);
        checkOutput("ovf_sticky", {63'd0, creditErr}, 64'd1);
        doReset();
        checkOutput("ovf_cleared", {63'd0, creditErr}, 64'd0);

        // stray BODY in IDLE, then HEAD, HEAD
        fifoQ.push_back(32'h0000_00AA);
        applyStimulus(1'b0, 1'b0);
        checkOutput("body_data", {32'd0, linkData}, 64'h0000_00AA);
        checkOutput("body_proto_err", {63'd0, protoErr}, 64'd1);
        fifoQ.push_back(mkFlit(2'b01, 30'h1));
        fifoQ.push_back(mkFlit(2'b01, 30'h2));
        repeat (3) applyStimulus(1'b0, 1'b0);
        checkOutput("head_head_err", {63'd0, protoErr}, 64'd1);

        // reset mid-packet
        doReset();
        fifoQ.push_back(mkFlit(2'b01, 30'h5));
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("midrst_active", {63'd0, pktActive}, 64'd0);
        checkOutput("midrst_credits", {60'd0, credits}, 64'd8);
        checkOutput("midrst_valid", {63'd0, linkValid}, 64'd0);

        // randomized traffic with occasional resets
        doReset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 2) != 0 && fifoQ.size() < 6)
                fifoQ.push_back(mkFlit(2'($urandom_range(0, 3)), 30'($urandom)));
            applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 99) == 0);
        end

        // pkt_count wrap: 65535 singles, then one more
        doReset();
        for (int i = 0; i < 65535; i++) begin
            fifoQ.push_back(mkFlit(2'b11, 30'(i)));
            applyStimulus(1'b1, 1'b0);
        end
        checkOutput("wrap_ffff", {48'd0, pktCount}, 64'hFFFF);
        fifoQ.push_back(mkFlit(2'b11, 30'h7));
        applyStimulus(1'b1, 1'b0);
        checkOutput("wrap_zero", {48'd0, pktCount}, 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
